l1_tag_lookup: RTL and testbench

- Two-stage tag lookup for a 4-way set-associative L1 cache.
- Stage 1 reads the per-way tag SRAMs and drives the pseudo-LRU block's read side.
- Stage 2 compares tags, reports hit/miss and hit way, and picks a victim from the LRU way.
- Sits directly upstream of the LRU block: it produces that block's access/set and update/new-MRU inputs, and consumes its LRU way output.

---
 rtl/l1_cache_pkg.sv | 21 ++
 rtl/l1_tag_lookup_way.sv | 74 +++++++
 rtl/l1_tag_lookup.sv | 108 ++++++++++
 tb/tb_l1_tag_lookup.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and sizes for the L1 cache tag path.
// Optional statistics counters are enabled with L1_TAG_STATS_EN.
package l1_cache_pkg;

    localparam int NUM_SETS        = 32;
    localparam int SET_INDEX_WIDTH = 5;
    localparam int TAG_WIDTH       = 21;
    localparam int NUM_WAYS        = 4;
    localparam int WAY_INDEX_WIDTH = 2;

    typedef logic [WAY_INDEX_WIDTH-1:0] way_idx_t;
    typedef logic [TAG_WIDTH-1:0]       cache_tag_t;
    typedef logic [SET_INDEX_WIDTH-1:0] set_idx_t;

    typedef struct packed {
        logic       valid;
        set_idx_t   set;
        cache_tag_t tag;
    } lookup_s2_t;

endpackage

// File: rtl/l1_tag_lookup_way.sv
// One way of the L1 tag store: tag SRAM, valid flops and both bypasses.
// Produces the stage-2 match bit for that way.
module cache_tag_way
    import l1_cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en,
    input  logic [SET_INDEX_WIDTH-1:0] rd_set,
    input  logic [SET_INDEX_WIDTH-1:0] s2_set,
    input  logic [TAG_WIDTH-1:0]       s2_tag,
    input  logic                       fill_en,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    input  logic [TAG_WIDTH-1:0]       fill_tag,
    input  logic                       inval_en,
    input  logic [SET_INDEX_WIDTH-1:0] inval_set,
    output logic                       match
);

    cache_tag_t            tag_mem [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q;
    cache_tag_t            rd_tag_q;
    logic                  rd_vld_q;

    logic fill_rd_hit;
    logic inval_rd_hit;
    logic fill_s2_hit;
    logic inval_s2_hit;

    assign fill_rd_hit  = fill_en  && (fill_set  == rd_set);
    assign inval_rd_hit = inval_en && (inval_set == rd_set);
    assign fill_s2_hit  = fill_en  && (fill_set  == s2_set);
    assign inval_s2_hit = inval_en && (inval_set == s2_set);

    // Tag SRAM: no reset, write-first read port.
    always_ff @(posedge clk) begin
        if (fill_en)
            tag_mem[fill_set] <= fill_tag;
        if (rd_en)
            rd_tag_q <= fill_rd_hit ? fill_tag : tag_mem[rd_set];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            if (inval_en)
                valid_q[inval_set] <= 1'b0;
            if (fill_en)
                valid_q[fill_set] <= 1'b1;
            if (rd_en)
                rd_vld_q <= fill_rd_hit |
                            (~inval_rd_hit & valid_q[rd_set]);
        end
    end

    cache_tag_t tag_eff;
    logic       vld_eff;

    always_comb begin
        tag_eff = rd_tag_q;
        vld_eff = rd_vld_q;
        if (fill_s2_hit) begin
            tag_eff = fill_tag;
            vld_eff = 1'b1;
        end else if (inval_s2_hit) begin
            vld_eff = 1'b0;
        end
    end

    assign match = vld_eff && (tag_eff == s2_tag);

endmodule

// File: rtl/l1_tag_lookup.sv
// Two-stage 4-way L1 tag lookup feeding the pseudo-LRU block.
// Define L1_TAG_STATS_EN to add hit/miss counters.
module l1_tag_lookup
    import l1_cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       request_i,
    input  logic [SET_INDEX_WIDTH-1:0] request_set_i,
    input  logic [TAG_WIDTH-1:0]       request_tag_i,
    input  logic                       fill_en_i,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set_i,
    input  logic [1:0]                 fill_way_i,
    input  logic [TAG_WIDTH-1:0]       fill_tag_i,
    input  logic                       inval_en_i,
    input  logic [SET_INDEX_WIDTH-1:0] inval_set_i,
    input  logic [1:0]                 inval_way_i,
    output logic                       lru_access_o,
    output logic [SET_INDEX_WIDTH-1:0] lru_set_o,
    input  logic [1:0]                 lru_way_i,
    output logic                       lru_update_o,
    output logic [1:0]                 lru_new_mru_o,
`ifdef L1_TAG_STATS_EN
    output logic [31:0]                hit_count_o,
    output logic [31:0]                miss_count_o,
`endif
    output logic                       lookup_valid_o,
    output logic                       hit_o,
    output logic [1:0]                 hit_way_o,
    output logic [1:0]                 victim_way_o
);

    lookup_s2_t          s2_q;
    logic [NUM_WAYS-1:0] match;
    way_idx_t            hit_way;
    way_idx_t            victim;
    logic                hit;

    assign lru_access_o = request_i;
    assign lru_set_o    = request_set_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_q <= '0;
        end else begin
            s2_q.valid <= request_i;
            if (request_i) begin
                s2_q.set <= request_set_i;
                s2_q.tag <= request_tag_i;
            end
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        cache_tag_way u_way (
            .clk       (clk),
            .reset     (reset),
            .rd_en     (request_i),
            .rd_set    (request_set_i),
            .s2_set    (s2_q.set),
            .s2_tag    (s2_q.tag),
            .fill_en   (fill_en_i && (fill_way_i == way_idx_t'(w))),
            .fill_set  (fill_set_i),
            .fill_tag  (fill_tag_i),
            .inval_en  (inval_en_i && (inval_way_i == way_idx_t'(w))),
            .inval_set (inval_set_i),
            .match     (match[w])
        );
    end

    // Multiple matches are illegal; lowest way wins regardless.
    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (match[w])
                hit_way = way_idx_t'(w);
    end

    assign hit    = s2_q.valid && (|match);
    assign victim = hit ? hit_way : lru_way_i;

    assign lookup_valid_o = s2_q.valid;
    assign hit_o          = hit;
    assign hit_way_o      = hit ? hit_way : '0;
    assign victim_way_o   = s2_q.valid ? victim : '0;
    assign lru_update_o   = s2_q.valid;
    assign lru_new_mru_o  = s2_q.valid ? victim : '0;

    a_one_match: assert property (
        @(posedge clk) disable iff (reset)
        s2_q.valid |-> $onehot0(match)
    );

`ifdef L1_TAG_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (s2_q.valid) begin
            if (hit)
                hit_count_o  <= hit_count_o + 32'd1;
            else
                miss_count_o <= miss_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1_tag_lookup.sv
// Directed bench for l1_tag_lookup with a tree pseudo-LRU model
// standing in for the downstream LRU block.
module tb_l1_tag_lookup;

    logic        clk;
    logic        reset;
    logic        request_i;
    logic [4:0]  request_set_i;
    logic [20:0] request_tag_i;
    logic        fill_en_i;
    logic [4:0]  fill_set_i;
    logic [1:0]  fill_way_i;
    logic [20:0] fill_tag_i;
    logic        inval_en_i;
    logic [4:0]  inval_set_i;
    logic [1:0]  inval_way_i;
    logic        lru_access_o;
    logic [4:0]  lru_set_o;
    logic [1:0]  lru_way_i;
    logic        lru_update_o;
    logic [1:0]  lru_new_mru_o;
    logic        lookup_valid_o;
    logic        hit_o;
    logic [1:0]  hit_way_o;
    logic [1:0]  victim_way_o;

    int n_vec;
    int n_err;

    l1_tag_lookup dut (
        .clk            (clk),
        .reset          (reset),
        .request_i      (request_i),
        .request_set_i  (request_set_i),
        .request_tag_i  (request_tag_i),
        .fill_en_i      (fill_en_i),
        .fill_set_i     (fill_set_i),
        .fill_way_i     (fill_way_i),
        .fill_tag_i     (fill_tag_i),
        .inval_en_i     (inval_en_i),
        .inval_set_i    (inval_set_i),
        .inval_way_i    (inval_way_i),
        .lru_access_o   (lru_access_o),
        .lru_set_o      (lru_set_o),
        .lru_way_i      (lru_way_i),
        .lru_update_o   (lru_update_o),
        .lru_new_mru_o  (lru_new_mru_o),
        .lookup_valid_o (lookup_valid_o),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .victim_way_o   (victim_way_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tree PLRU: bit0 root (0 = left half is LRU), bit1 left, bit2 right.
    logic [2:0] plru [32];
    logic [4:0] lru_set_q;

    function automatic logic [2:0] plru_touch(logic [2:0] s, logic [1:0] w);
        logic [2:0] r;
        r = s;
        if (!w[1]) begin
            r[0] = 1'b1;
            r[1] = ~w[0];
        end else begin
            r[0] = 1'b0;
            r[2] = ~w[0];
        end
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(logic [2:0] s);
        return s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                plru[i] <= 3'b000;
            lru_set_q <= '0;
        end else begin
            if (lru_update_o)
                plru[lru_set_q] <= plru_touch(plru[lru_set_q], lru_new_mru_o);
            if (lru_access_o)
                lru_set_q <= lru_set_o;
        end
    end

    assign lru_way_i = plru_victim(plru[lru_set_q]);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        request_i  = 1'b0;
        fill_en_i  = 1'b0;
        inval_en_i = 1'b0;
    endtask

    task automatic req(input logic [4:0] s, input logic [20:0] t);
        request_i     = 1'b1;
        request_set_i = s;
        request_tag_i = t;
    endtask

    task automatic fill(input logic [4:0] s, input logic [1:0] w,
                        input logic [20:0] t);
        fill_en_i  = 1'b1;
        fill_set_i = s;
        fill_way_i = w;
        fill_tag_i = t;
    endtask

    task automatic inval(input logic [4:0] s, input logic [1:0] w);
        inval_en_i  = 1'b1;
        inval_set_i = s;
        inval_way_i = w;
    endtask

    logic [1:0] exp_vict [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        request_set_i = '0; request_tag_i = '0;
        fill_set_i = '0; fill_way_i = '0; fill_tag_i = '0;
        inval_set_i = '0; inval_way_i = '0;
        req(5'd3, 21'h1ABCD);
        #3;
        chk("rst_valid",  32'(lookup_valid_o), 32'd0);
        chk("rst_hit",    32'(hit_o),          32'd0);
        chk("rst_hitway", 32'(hit_way_o),      32'd0);
        chk("rst_victim", 32'(victim_way_o),   32'd0);
        chk("rst_upd",    32'(lru_update_o),   32'd0);
        chk("rst_mru",    32'(lru_new_mru_o),  32'd0);
        chk("rst_access", 32'(lru_access_o),   32'd1);
        chk("rst_set",    32'(lru_set_o),      32'd3);
        idle();
        #9 reset = 1'b0;
        tick();

        // Cold miss: LRU for set 3 is fresh, victim way 0.
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        @(negedge clk);
        chk("miss_valid",  32'(lookup_valid_o), 32'd1);
        chk("miss_hit",    32'(hit_o),          32'd0);
        chk("miss_hitway", 32'(hit_way_o),      32'd0);
        chk("miss_victim", 32'(victim_way_o),   32'd0);
        chk("miss_upd",    32'(lru_update_o),   32'd1);
        chk("miss_mru",    32'(lru_new_mru_o),  32'd0);
        tick();
        chk("idle_valid",  32'(lookup_valid_o), 32'd0);

        fill(5'd3, 2'd2, 21'h1ABCD);
        tick(); idle();
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        @(negedge clk);
        chk("hit_hit",    32'(hit_o),         32'd1);
        chk("hit_way",    32'(hit_way_o),     32'd2);
        chk("hit_mru",    32'(lru_new_mru_o), 32'd2);
        chk("hit_victim", 32'(victim_way_o),  32'd2);
        tick();

        // Fill and read of set 5 in the same cycle.
        req(5'd5, 21'h00042);
        fill(5'd5, 2'd1, 21'h00042);
        tick(); idle();
        @(negedge clk);
        chk("wf_hit", 32'(hit_o),     32'd1);
        chk("wf_way", 32'(hit_way_o), 32'd1);
        tick();

        // Fill arriving during stage 2.
        req(5'd9, 21'h00055);
        tick(); idle();
        fill(5'd9, 2'd3, 21'h00055);
        @(negedge clk);
        chk("s2f_hit", 32'(hit_o),     32'd1);
        chk("s2f_way", 32'(hit_way_o), 32'd3);
        tick(); idle();

        // Invalidate during stage 2; set 3 PLRU now points at way 1.
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        inval(5'd3, 2'd2);
        @(negedge clk);
        chk("s2i_hit",    32'(hit_o),        32'd0);
        chk("s2i_hitway", 32'(hit_way_o),    32'd0);
        chk("s2i_victim", 32'(victim_way_o), 32'd1);
        tick(); idle();
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        @(negedge clk);
        chk("inv_miss", 32'(hit_o), 32'd0);
        tick();

        fill(5'd3, 2'd2, 21'h1ABCD);
        inval(5'd3, 2'd2);
        tick(); idle();
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        @(negedge clk);
        chk("fi_hit", 32'(hit_o),     32'd1);
        chk("fi_way", 32'(hit_way_o), 32'd2);
        tick();

        // Four back-to-back misses to set 7 rotate through all ways.
        exp_vict[0] = 2'd0;
        exp_vict[1] = 2'd2;
        exp_vict[2] = 2'd1;
        exp_vict[3] = 2'd3;
        req(5'd7, 21'h07777);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) idle();
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", i), 32'(lookup_valid_o), 32'd1);
            chk($sformatf("b2b_hit%0d", i),   32'(hit_o),          32'd0);
            chk($sformatf("b2b_vict%0d", i),  32'(victim_way_o),
                32'(exp_vict[i]));
            chk($sformatf("b2b_mru%0d", i),   32'(lru_new_mru_o),
                32'(exp_vict[i]));
        end
        tick();

        // Reset in the middle of a stage-2 hit.
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        #1 reset = 1'b1;
        #1;
        chk("mr_valid", 32'(lookup_valid_o), 32'd0);
        chk("mr_hit",   32'(hit_o),          32'd0);
        chk("mr_upd",   32'(lru_update_o),   32'd0);
        chk("mr_mru",   32'(lru_new_mru_o),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        req(5'd3, 21'h1ABCD);
        tick(); idle();
        @(negedge clk);
        chk("post_valid", 32'(lookup_valid_o), 32'd1);
        chk("post_hit",   32'(hit_o),          32'd0);
        chk("post_vict",  32'(victim_way_o),   32'd0);
        req(5'd5, 21'h00042);
        tick(); idle();
        @(negedge clk);
        chk("post_hit5",  32'(hit_o),          32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
